dispatch_feeder: RTL and testbench

- In-order dispatch buffer between rename and the 2-bank issue queue.
- Accepts up to 2 renamed instructions per cycle from rename with a valid/ready handshake and stores them in a circular FIFO.
- Presents the 4 oldest entries on the issue queue's 4 insertion slots and pops them when the queue accepts.
- Handles branch kill by truncating the young tail of the FIFO.

---
 rtl/dispatch_feeder_if.sv | 42 ++++
 rtl/dispatch_feeder.sv | 151 +++++++++++++++
 tb/tb_dispatch_feeder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_feeder_if.sv
// ---------------------------------------------------------------------------
// dispatch_feeder_if
// Rename-side and issue-queue-side signals of the dispatch buffer.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface dispatch_feeder_if #(
  parameter int WIDTH_I   = 33,
  parameter int WIDTH_BRM = 3
);
  // rename side
  logic [WIDTH_I-1:0]   i_inst1;
  logic [WIDTH_I-1:0]   i_inst2;
  logic [1:0]           i_valid;
  logic                 o_ready;
  // issue queue side
  logic [WIDTH_I-1:0]   o_inst1;
  logic [WIDTH_I-1:0]   o_inst2;
  logic [WIDTH_I-1:0]   o_inst3;
  logic [WIDTH_I-1:0]   o_inst4;
  logic [3:0]           o_valid;
  logic                 o_en;
  logic                 i_qready;
  // branch kill {enKill, BranchMask} and status
  logic [WIDTH_BRM:0]   i_BrKill;
  logic                 o_empty;

  // buffer view
  modport slave (
    input  i_inst1, i_inst2, i_valid, i_qready, i_BrKill,
    output o_ready, o_inst1, o_inst2, o_inst3, o_inst4, o_valid, o_en, o_empty
  );

  // rename / issue queue / bench view
  modport master (
    output i_inst1, i_inst2, i_valid, i_qready, i_BrKill,
    input  o_ready, o_inst1, o_inst2, o_inst3, o_inst4, o_valid, o_en, o_empty
  );
endinterface

`default_nettype wire

// File: rtl/dispatch_feeder.sv
// ---------------------------------------------------------------------------
// dispatch_feeder
// In-order dispatch buffer between rename and the issue queue. Accepts up to
// two instructions per cycle, shows the four oldest entries to the issue
// queue and pops them on insert; branch kill truncates the young tail.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module dispatch_feeder #(
  parameter int DEPTH     = 8,
  parameter int WIDTH_REG = 5,
  parameter int WIDTH_TAG = 5,
  parameter int WIDTH_BRM = 3,
  parameter int WIDTH_I   = 7 + WIDTH_BRM + WIDTH_TAG + 3*WIDTH_REG + 3,
  parameter int BRM_LSB   = WIDTH_TAG + 3*WIDTH_REG + 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  dispatch_feeder_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  // storage and pointers
  logic [WIDTH_I-1:0] mem_q [DEPTH];
  ptr_t               head_q, head_d;
  ptr_t               tail_q, tail_d;
  cnt_t               count_q, count_d;

  // entries re-indexed relative to head (rel[0] is the oldest)
  logic [WIDTH_I-1:0] rel [DEPTH];

  logic                 kill_en;
  logic [WIDTH_BRM-1:0] kill_mask;
  cnt_t                 kill_m;
  logic [2:0]           n_out;
  logic [WIDTH_I-1:0]   slot [4];
  logic [3:0]           valid_out;
  logic                 ready;
  logic                 en;
  cnt_t                 push_n;
  cnt_t                 pop_n;
  ptr_t                 tail_p1;

  assign kill_en   = bus.i_BrKill[WIDTH_BRM];
  assign kill_mask = bus.i_BrKill[WIDTH_BRM-1:0];
  assign tail_p1   = tail_q + ptr_t'(1);

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_rel
      localparam ptr_t OFF = ptr_t'(g);
      assign rel[g] = mem_q[head_q + OFF];
    end
  endgenerate

  // Offset of the oldest entry hit by the kill mask; matches form a young
  // suffix, so scanning from the young end and keeping the last hit suffices.
  always_comb begin
    kill_m = count_q;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if ((cnt_t'(k) < count_q) &&
          (|(rel[k][BRM_LSB +: WIDTH_BRM] & kill_mask))) begin
        kill_m = cnt_t'(k);
      end
    end
  end

  // Show-ahead output view: up to four oldest entries, zero beyond count.
  always_comb begin
    n_out = (count_q >= cnt_t'(4)) ? 3'd4 : count_q[2:0];
    for (int k = 0; k < 4; k++) begin
      valid_out[k] = (3'(k) < n_out);
      slot[k]      = valid_out[k] ? rel[k] : '0;
    end
  end

  assign ready = (count_q <= cnt_t'(DEPTH - 2)) && !kill_en;
  assign en    = (count_q != '0) && bus.i_qready && !kill_en;

  assign bus.o_ready = ready;
  assign bus.o_en    = en;
  assign bus.o_valid = valid_out;
  assign bus.o_inst1 = slot[0];
  assign bus.o_inst2 = slot[1];
  assign bus.o_inst3 = slot[2];
  assign bus.o_inst4 = slot[3];
  assign bus.o_empty = (count_q == '0);

  // Number of entries accepted from rename and handed to the issue queue.
  always_comb begin
    push_n = '0;
    if (ready) begin
      case (bus.i_valid)
        2'b11:        push_n = cnt_t'(2);
        2'b01, 2'b10: push_n = cnt_t'(1);
        default:      push_n = '0;
      endcase
    end
    pop_n = en ? cnt_t'(n_out) : '0;
  end

  // Pointer/count next state; a kill overrides push and pop for the cycle.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (kill_en) begin
      tail_d  = head_q + ptr_t'(kill_m);
      count_d = kill_m;
    end else begin
      head_d  = head_q + ptr_t'(pop_n);
      tail_d  = tail_q + ptr_t'(push_n);
      count_d = count_q + push_n - pop_n;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage write; a lone inst2 is compacted into the tail slot.
  always_ff @(posedge i_clk) begin
    if (push_n != '0) begin
      if (bus.i_valid[0]) begin
        mem_q[tail_q] <= bus.i_inst1;
        if (bus.i_valid[1]) begin
          mem_q[tail_p1] <= bus.i_inst2;
        end
      end else begin
        mem_q[tail_q] <= bus.i_inst2;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dispatch_feeder.sv
// ---------------------------------------------------------------------------
// tb_dispatch_feeder
// Directed bench for dispatch_feeder with a FIFO scoreboard of popped data.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dispatch_feeder;

  localparam int W   = 33;
  localparam int BRM = 3;
  localparam logic [W-1:0] MASK010 = 33'h100_0000; // bit 24 = mask field 010

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] mon_out [4];

  dispatch_feeder_if #(.WIDTH_I(W), .WIDTH_BRM(BRM)) bus ();

  dispatch_feeder dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    mon_out[0] = bus.o_inst1;
    mon_out[1] = bus.o_inst2;
    mon_out[2] = bus.o_inst3;
    mon_out[3] = bus.o_inst4;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // monitor: whenever the buffer strobes an insert, each valid slot must be
  // the next expected instruction in program order
  always @(negedge clk) begin
    if (rst_n && bus.o_en === 1'b1) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.o_valid[k]) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow slot=%0d actual=%0h required=none", k, mon_out[k]);
          end else begin
            chk("sb_data", {31'd0, mon_out[k]}, {31'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] v, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic qr, input logic [3:0] kill);
    bus.i_valid  = v;
    bus.i_inst1  = a;
    bus.i_inst2  = b;
    bus.i_qready = qr;
    bus.i_BrKill = kill;
  endtask

  // drive a push; exp_rdy is the hand-derived acceptance for this cycle
  task automatic push(input logic [1:0] v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic qr, input logic exp_rdy);
    next();
    drv(v, a, b, qr, 4'b0000);
    #1;
    chk("push_ready", {63'd0, bus.o_ready}, {63'd0, exp_rdy});
    if (exp_rdy) begin
      if (v[0]) exp_q.push_back(a);
      if (v[1]) exp_q.push_back(b);
    end
  endtask

  task automatic idle(input logic qr);
    next();
    drv(2'b00, '0, '0, qr, 4'b0000);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drv(2'b00, '0, '0, 1'b0, 4'b0000);
    #12;
    chk("rst_valid", {60'd0, bus.o_valid}, 64'd0);
    chk("rst_en",    {63'd0, bus.o_en},    64'd0);
    chk("rst_empty", {63'd0, bus.o_empty}, 64'd1);
    chk("rst_ready", {63'd0, bus.o_ready}, 64'd1);
    chk("rst_inst1", {31'd0, bus.o_inst1}, 64'd0);
    rst_n = 1'b1;

    // basic pair, show-ahead, then pass to the queue
    push(2'b11, 33'h0A01, 33'h0B02, 1'b0, 1'b1);
    idle(1'b0);
    chk("t1_valid", {60'd0, bus.o_valid}, 64'h3);
    chk("t1_inst1", {31'd0, bus.o_inst1}, 64'h0A01);
    chk("t1_inst2", {31'd0, bus.o_inst2}, 64'h0B02);
    chk("t1_en0",   {63'd0, bus.o_en},    64'd0);
    idle(1'b1);
    chk("t1_en1",   {63'd0, bus.o_en},    64'd1);
    idle(1'b0);
    chk("t1_empty", {63'd0, bus.o_empty}, 64'd1);

    // fill to full; 5th and 6th pairs refused
    for (int p = 0; p < 6; p++)
      push(2'b11, 33'h100 + 33'(2*p), 33'h101 + 33'(2*p), 1'b0, (p < 4));
    idle(1'b0);
    chk("full_ready", {63'd0, bus.o_ready}, 64'd0);
    chk("full_valid", {60'd0, bus.o_valid}, 64'hF);
    idle(1'b1);
    chk("pop1_en",    {63'd0, bus.o_en},    64'd1);
    chk("pop1_valid", {60'd0, bus.o_valid}, 64'hF);
    idle(1'b1);
    chk("pop2_en",    {63'd0, bus.o_en},    64'd1);
    chk("pop2_valid", {60'd0, bus.o_valid}, 64'hF);
    chk("pop2_inst1", {31'd0, bus.o_inst1}, 64'h104);
    idle(1'b1);
    chk("fill_empty", {63'd0, bus.o_empty}, 64'd1);
    chk("empty_en",   {63'd0, bus.o_en},    64'd0);

    // move head from 2 to 6 with overlapping push/pop
    push(2'b11, 33'h201, 33'h202, 1'b1, 1'b1);
    chk("x_en0", {63'd0, bus.o_en}, 64'd0);
    push(2'b11, 33'h203, 33'h204, 1'b1, 1'b1);
    chk("x_en1", {63'd0, bus.o_en}, 64'd1);
    idle(1'b1);
    idle(1'b0);
    chk("x_empty", {63'd0, bus.o_empty}, 64'd1);

    // fill again from head 6 so the first group straddles the wrap
    for (int p = 0; p < 4; p++)
      push(2'b11, 33'h300 + 33'(2*p), 33'h301 + 33'(2*p), 1'b0, 1'b1);
    idle(1'b1);
    chk("wrap_inst1", {31'd0, bus.o_inst1}, 64'h300);
    chk("wrap_inst4", {31'd0, bus.o_inst4}, 64'h303);
    idle(1'b1);
    chk("wrap2_inst1", {31'd0, bus.o_inst1}, 64'h304);
    idle(1'b0);
    chk("wrap_empty", {63'd0, bus.o_empty}, 64'd1);

    // lone inst2 is compacted to slot 1
    push(2'b10, 33'h1DEAD, 33'h0C0C, 1'b0, 1'b1);
    idle(1'b0);
    chk("c_inst1", {31'd0, bus.o_inst1}, 64'h0C0C);
    chk("c_inst2", {31'd0, bus.o_inst2}, 64'h0);
    chk("c_valid", {60'd0, bus.o_valid}, 64'h1);
    idle(1'b1);

    // branch kill truncates E3..E5
    push(2'b11, 33'h0E00, 33'h0E01, 1'b0, 1'b1);
    push(2'b11, 33'h0E02, MASK010 | 33'h0E03, 1'b0, 1'b1);
    push(2'b11, MASK010 | 33'h0E04, MASK010 | 33'h0E05, 1'b0, 1'b1);
    next();
    drv(2'b11, 33'h1111, 33'h2222, 1'b1, 4'b1010);
    #1;
    chk("kill_en",    {63'd0, bus.o_en},    64'd0);
    chk("kill_ready", {63'd0, bus.o_ready}, 64'd0);
    repeat (3) void'(exp_q.pop_back());
    idle(1'b0);
    chk("kill_valid", {60'd0, bus.o_valid}, 64'h7);
    chk("kill_inst1", {31'd0, bus.o_inst1}, 64'h0E00);
    chk("kill_inst3", {31'd0, bus.o_inst3}, 64'h0E02);
    push(2'b01, 33'h0F0F, 33'h1234, 1'b0, 1'b1);
    idle(1'b0);
    chk("kill_inst4", {31'd0, bus.o_inst4}, 64'h0F0F);
    chk("kill_valid4", {60'd0, bus.o_valid}, 64'hF);
    idle(1'b1);
    idle(1'b0);
    chk("kill_empty", {63'd0, bus.o_empty}, 64'd1);
    chk("drain1", 64'(exp_q.size()), 64'd0);

    // mid-cycle reset with traffic in flight
    push(2'b11, 33'h500, 33'h501, 1'b0, 1'b1);
    push(2'b11, 33'h502, 33'h503, 1'b0, 1'b1);
    push(2'b01, 33'h504, 33'h0,   1'b0, 1'b1);
    next();
    drv(2'b11, 33'h505, 33'h506, 1'b1, 4'b0000);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {60'd0, bus.o_valid}, 64'd0);
    chk("mrst_en",    {63'd0, bus.o_en},    64'd0);
    chk("mrst_empty", {63'd0, bus.o_empty}, 64'd1);
    chk("mrst_ready", {63'd0, bus.o_ready}, 64'd1);
    drv(2'b00, '0, '0, 1'b0, 4'b0000);
    exp_q.delete();
    #1;
    rst_n = 1'b1;

    // buffer works again after reset
    push(2'b11, 33'h600, 33'h601, 1'b1, 1'b1);
    idle(1'b1);
    chk("post_en", {63'd0, bus.o_en}, 64'd1);
    idle(1'b0);
    chk("post_empty", {63'd0, bus.o_empty}, 64'd1);
    chk("drain2", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
